// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

   // Controller state: IDLE grants requests, RMW performs the write half of
   // a partial-word store.
   typedef enum logic {
      IDLE = 1'b0,
      RMW  = 1'b1
   } state_e;

   // Requester indices into the arbiter request/grant vectors.
   localparam int PORT_IF = 0;
   localparam int PORT_D  = 1;

   // Per-lane merge: lane i takes new_w when be[i] is set, else keeps old_w.
   function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted most recently wins. Grants are combinational; the last-grant flag
// only moves when a grant is actually issued.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       en,     // grants allowed this cycle
   input  logic [1:0] req,
   output logic [1:0] gnt     // one-hot, or zero
);

   logic last_q;   // 1 = PORT_D granted most recently
   logic last_d;

   // Pick at most one requester; ties go to the one not served last.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[PORT_IF] && req[PORT_D]) begin
            if (last_q) gnt[PORT_IF] = 1'b1;
            else        gnt[PORT_D]  = 1'b1;
         end else if (req[PORT_IF]) begin
            gnt[PORT_IF] = 1'b1;
         end else if (req[PORT_D]) begin
            gnt[PORT_D] = 1'b1;
         end
      end
   end

   // Remember who was served; hold when nothing was granted.
   always_comb begin
      last_d = last_q;
      if (gnt[PORT_IF])     last_d = 1'b0;
      else if (gnt[PORT_D]) last_d = 1'b1;
   end

   // Last-grant register; reset to data so fetch wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide RAM between the fetch port and the load/store port.
// Handshake: a requester raises *_req with stable address/data and holds it
// until *_gnt is seen high in the same cycle; the transfer is accepted in that
// cycle and *_rvalid pulses once when the result (or store completion) is
// ready. Partial-word stores become a read (grant cycle) followed by a
// whole-word write in the next cycle, during which nothing is granted.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              dbg_state   // 1 while in RMW
);

   state_e            state_q, state_d;
   logic [1:0]        req, gnt;
   logic              d_partial;
   logic              if_rvalid_q, d_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
   logic [ADDR_W-1:0] rmw_addr_q;
   logic [3:0]        rmw_be_q;
   logic [DATA_W-1:0] rmw_new_q, rmw_old_q;
   logic              unused_addr_lsbs;

   // Byte offsets within a word are deliberately ignored.
   assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

   assign req[PORT_IF] = if_req;
   assign req[PORT_D]  = d_req;
   assign d_partial    = d_we && (d_be != 4'b1111) && (d_be != 4'b0000);

   rr_arbiter2 u_arb (
      .clock (clock),
      .reset (reset),
      .en    ((state_q == IDLE) && !reset),
      .req   (req),
      .gnt   (gnt)
   );

   assign if_gnt    = gnt[PORT_IF];
   assign d_gnt     = gnt[PORT_D];
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign dbg_state = (state_q == RMW);

   // Next state and RAM drive: RMW writes the merged word, IDLE serves the grant.
   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_addr  = {if_addr[ADDR_W-1:2], 2'b00};
      ram_wdata = d_wdata;
      if (state_q == RMW) begin
         ram_addr  = rmw_addr_q;
         ram_we    = !reset;
         ram_wdata = merge_be(rmw_old_q, rmw_new_q, rmw_be_q);
         state_d   = IDLE;
      end else if (gnt[PORT_D]) begin
         ram_addr = {d_addr[ADDR_W-1:2], 2'b00};
         ram_we   = d_we && (d_be == 4'b1111);
         if (d_partial) state_d = RMW;
      end
   end

   // State and response registers; read data holds between responses.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         if_rvalid_q <= gnt[PORT_IF];
         d_rvalid_q  <= (gnt[PORT_D] && !d_partial) || (state_q == RMW);
         if (gnt[PORT_IF]) if_rdata_q <= ram_rdata;
         if (gnt[PORT_D] && !d_we)           d_rdata_q <= ram_rdata;
         else if (gnt[PORT_D] && !d_partial) d_rdata_q <= '0;
         else if (state_q == RMW)            d_rdata_q <= '0;
      end
   end

   // Capture the partial store and the old word at grant time.
   always_ff @(posedge clock) begin
      if (gnt[PORT_D] && d_partial) begin
         rmw_addr_q <= {d_addr[ADDR_W-1:2], 2'b00};
         rmw_be_q   <= d_be;
         rmw_new_q  <= d_wdata;
         rmw_old_q  <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 64-word RAM, directed scenarios with literal
// expectations, then random traffic on both ports, all tracked by a
// transaction-level model checked every cycle.
module tb_mem_arbiter;

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        if_req   = 1'b0;
   logic [31:0] if_addr  = '0;
   logic        d_req    = 1'b0;
   logic        d_we     = 1'b0;
   logic [3:0]  d_be     = '0;
   logic [31:0] d_addr   = '0;
   logic [31:0] d_wdata  = '0;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, ram_we, dbg_state;
   logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int we_cnt = 0;
   bit chk_en = 1'b0;

   // Bench RAM plus a back-door write port used only while the DUT is quiet.
   logic [31:0] ram_mem [0:63];
   logic [31:0] ref_mem [0:63];
   logic        tb_wr = 1'b0;
   logic [5:0]  tb_idx = '0;
   logic [31:0] tb_data = '0;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .dbg_state (dbg_state)
   );

   assign ram_rdata = ram_mem[ram_addr[7:2]];

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (ram_we === 1'b1)  ram_mem[ram_addr[7:2]] <= ram_wdata;
      else if (tb_wr)       ram_mem[tb_idx] <= tb_data;
   end

   always @(negedge clock) begin
      if (ram_we === 1'b1) we_cnt = we_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          if_rv_nxt = 0, d_rv_nxt = 0, d_rv_nxt2 = 0, rmw_pend = 0, m_last = 1;
   bit          if_rv_now, d_rv_now;
   logic [31:0] if_data_nxt = '0, d_data_nxt = '0, d_data_nxt2 = '0;
   logic [31:0] m_if_rdata = '0, m_d_rdata = '0, rmw_addr = '0, rmw_word = '0;
   logic [31:0] mask, old_w;
   int          win;

   always @(negedge clock) begin
      if (chk_en) begin
         // responses scheduled by earlier cycles become visible now
         if_rv_now = if_rv_nxt;
         if_rv_nxt = 1'b0;
         if (if_rv_now) m_if_rdata = if_data_nxt;
         d_rv_now = d_rv_nxt;
         if (d_rv_now) m_d_rdata = d_data_nxt;
         d_rv_nxt    = d_rv_nxt2;
         d_data_nxt  = d_data_nxt2;
         d_rv_nxt2   = 1'b0;
         chk("if_rvalid", 32'(if_rvalid), 32'(if_rv_now));
         chk("d_rvalid",  32'(d_rvalid),  32'(d_rv_now));
         chk("if_rdata",  if_rdata, m_if_rdata);
         chk("d_rdata",   d_rdata,  m_d_rdata);
         chk("dbg_state", 32'(dbg_state), 32'(rmw_pend));
         if (reset) begin
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
            chk("rst_d_gnt",  32'(d_gnt),  32'd0);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            if_rv_nxt = 0; d_rv_nxt = 0; d_rv_nxt2 = 0; rmw_pend = 0; m_last = 1;
            m_if_rdata = '0; m_d_rdata = '0;
         end else if (rmw_pend) begin
            chk("rmw_if_gnt",   32'(if_gnt), 32'd0);
            chk("rmw_d_gnt",    32'(d_gnt),  32'd0);
            chk("rmw_ram_we",   32'(ram_we), 32'd1);
            chk("rmw_ram_addr", ram_addr, rmw_addr);
            chk("rmw_wdata",    ram_wdata, rmw_word);
            ref_mem[rmw_addr[7:2]] = rmw_word;
            rmw_pend = 0;
         end else begin
            win = -1;
            if (if_req && d_req) win = m_last ? 0 : 1;
            else if (if_req)     win = 0;
            else if (d_req)      win = 1;
            chk("if_gnt", 32'(if_gnt), 32'(win == 0));
            chk("d_gnt",  32'(d_gnt),  32'(win == 1));
            chk("ram_we", 32'(ram_we), 32'(win == 1 && d_we && d_be == 4'hF));
            if (win == 0) begin
               chk("ram_addr_if", ram_addr, if_addr & ~32'd3);
               if_rv_nxt = 1; if_data_nxt = ref_mem[if_addr[7:2]];
               m_last = 0;
            end else if (win == 1) begin
               chk("ram_addr_d", ram_addr, d_addr & ~32'd3);
               m_last = 1;
               if (!d_we) begin
                  d_rv_nxt = 1; d_data_nxt = ref_mem[d_addr[7:2]];
               end else if (d_be == 4'hF) begin
                  chk("ram_wdata", ram_wdata, d_wdata);
                  ref_mem[d_addr[7:2]] = d_wdata;
                  d_rv_nxt = 1; d_data_nxt = '0;
               end else if (d_be == 4'h0) begin
                  d_rv_nxt = 1; d_data_nxt = '0;
               end else begin
                  mask = {{8{d_be[3]}}, {8{d_be[2]}}, {8{d_be[1]}}, {8{d_be[0]}}};
                  old_w = ref_mem[d_addr[7:2]];
                  rmw_word = (old_w & ~mask) | (d_wdata & mask);
                  rmw_addr = d_addr & ~32'd3;
                  rmw_pend = 1;
                  d_rv_nxt2 = 1; d_data_nxt2 = '0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic poke(input int idx, input logic [31:0] data);
      tb_wr = 1'b1; tb_idx = 6'(idx); tb_data = data;
      ref_mem[idx] = data;
      @(posedge clock); #1;
      tb_wr = 1'b0;
   endtask

   task automatic wait_gnt(input bit port_d, output bit ok);
      int k = 0;
      ok = 1'b0;
      while (k < 40 && !ok) begin
         @(negedge clock);
         ok = port_d ? d_gnt : if_gnt;
         k++;
      end
      chk(port_d ? "d_gnt_seen" : "if_gnt_seen", 32'(ok), 32'd1);
   endtask

   task automatic do_fetch(input logic [31:0] addr, output logic [31:0] data);
      bit ok;
      if_addr = addr; if_req = 1'b1;
      wait_gnt(1'b0, ok);
      @(posedge clock); #1;
      if_req = 1'b0;
      @(negedge clock);
      chk("fetch_rvalid_n1", 32'(if_rvalid), 32'd1);
      data = if_rdata;
   endtask

   task automatic do_data(input bit we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] data, output int lat);
      bit ok;
      d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      wait_gnt(1'b1, ok);
      @(posedge clock); #1;
      d_req = 1'b0;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!d_rvalid && lat < 6);
      data = d_rdata;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rd;
   int          lat, we0;

   initial begin
      @(posedge clock); #1;
      chk_en = 1'b1;
      for (int i = 0; i < 64; i++) poke(i, $urandom);
      poke(4, 32'hDEADBEEF);
      poke(9, 32'hFFFFFFFF);
      poke(12, 32'h55555555);
      @(negedge clock);
      chk("reset_if_rdata", if_rdata, 32'd0);
      chk("reset_d_rvalid", 32'(d_rvalid), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // fetch only
      do_fetch(32'h10, rd);
      chk("fetch_data", rd, 32'hDEADBEEF);
      @(negedge clock);
      chk("fetch_rvalid_pulse", 32'(if_rvalid), 32'd0);

      // both request every cycle after a reset: IF, D, IF, D ...
      @(posedge clock); #1; reset = 1'b1;
      @(posedge clock); #1; reset = 1'b0;
      if_addr = 32'h20; d_addr = 32'h10; d_we = 1'b0; d_be = 4'hF;
      if_req = 1'b1; d_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("alt_if_gnt", 32'(if_gnt), 32'((i % 2) == 0));
         chk("alt_d_gnt",  32'(d_gnt),  32'((i % 2) == 1));
         @(posedge clock); #1;
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (2) @(posedge clock); #1;

      // full store then load
      we0 = we_cnt;
      do_data(1'b1, 4'hF, 32'h20, 32'h11223344, rd, lat);
      chk("full_st_lat", 32'(lat), 32'd1);
      chk("full_st_rdata", rd, 32'd0);
      chk("full_st_we_cycles", 32'(we_cnt - we0), 32'd1);
      @(posedge clock); #1;
      do_data(1'b0, 4'hF, 32'h20, 32'h0, rd, lat);
      chk("ld_after_st", rd, 32'h11223344);
      chk("ld_lat", 32'(lat), 32'd1);
      @(posedge clock); #1;

      // partial store, fetch competes during the write cycle
      d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h24; d_wdata = 32'h0000AB00; d_req = 1'b1;
      wait_gnt(1'b1, rd[0]);
      @(posedge clock); #1;
      d_req = 1'b0; if_addr = 32'h24; if_req = 1'b1;
      @(negedge clock);
      chk("rmw_no_if_gnt", 32'(if_gnt), 32'd0);
      chk("rmw_we", 32'(ram_we), 32'd1);
      chk("rmw_word", ram_wdata, 32'hFFFFABFF);
      chk("rmw_no_rvalid_n1", 32'(d_rvalid), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("rmw_rvalid_n2", 32'(d_rvalid), 32'd1);
      chk("rmw_if_gnt_n2", 32'(if_gnt), 32'd1);
      @(posedge clock); #1;
      if_req = 1'b0;
      @(negedge clock);
      chk("rmw_readback", if_rdata, 32'hFFFFABFF);
      @(posedge clock); #1;

      // empty-enable store, then misaligned load
      we0 = we_cnt;
      do_data(1'b1, 4'h0, 32'h20, 32'hCAFEF00D, rd, lat);
      chk("empty_st_lat", 32'(lat), 32'd1);
      chk("empty_st_no_we", 32'(we_cnt - we0), 32'd0);
      @(posedge clock); #1;
      do_data(1'b0, 4'hF, 32'h23, 32'h0, rd, lat);
      chk("ld_misaligned", rd, 32'h11223344);
      @(posedge clock); #1;

      // reset during the write cycle of a partial store
      we0 = we_cnt;
      d_we = 1'b1; d_be = 4'b0001; d_addr = 32'h30; d_wdata = 32'h000000AA; d_req = 1'b1;
      wait_gnt(1'b1, rd[0]);
      @(posedge clock); #1;
      d_req = 1'b0; reset = 1'b1;
      @(negedge clock);
      chk("rstrmw_we", 32'(ram_we), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("rstrmw_no_rvalid", 32'(d_rvalid), 32'd0);
      end
      chk("rstrmw_no_write", 32'(we_cnt - we0), 32'd0);
      chk("rstrmw_ram_word", ram_mem[12], 32'h55555555);
      @(posedge clock); #1;
      do_data(1'b0, 4'hF, 32'h30, 32'h0, rd, lat);
      chk("rstrmw_load", rd, 32'h55555555);
      @(posedge clock); #1;
      do_fetch(32'h10, rd);
      chk("rstrmw_fetch", rd, 32'hDEADBEEF);
      @(posedge clock); #1;

      // random traffic on both ports
      fork
         begin : drv_if
            bit ok;
            int gap;
            for (int n = 0; n < 150; n++) begin
               if_addr = 32'($urandom_range(0, 255));
               if_req = 1'b1;
               wait_gnt(1'b0, ok);
               @(posedge clock); #1;
               if_req = 1'b0;
               gap = $urandom_range(0, 2);
               repeat (gap) begin @(posedge clock); #1; end
            end
         end
         begin : drv_d
            bit ok;
            int gap, sel;
            for (int n = 0; n < 150; n++) begin
               d_we = 1'($urandom_range(0, 1));
               sel = $urandom_range(0, 3);
               d_be = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(1, 14));
               d_addr = 32'($urandom_range(0, 255));
               d_wdata = $urandom;
               d_req = 1'b1;
               wait_gnt(1'b1, ok);
               @(posedge clock); #1;
               d_req = 1'b0;
               gap = $urandom_range(0, 2);
               repeat (gap) begin @(posedge clock); #1; end
            end
         end
      join

      repeat (4) @(negedge clock);
      for (int i = 0; i < 64; i++) chk("ram_final", ram_mem[i], ref_mem[i]);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
